if_fetch_unit: RTL and testbench

Instruction-fetch stage front end: owns the PC register, issues one-at-a-time requests to instruction memory over a ready/valid handshake, and presents the fetched word plus PC+4 to the IF/ID pipeline register. It is the producer side of IF_Instruction / IF_PC_4. It honours the hazard unit's PCWrite stall and redirects on Branch (BTB_Addr) or JUMP (JUMP_Addr) from the ID stage. Any in-flight wrong-path fetch is discarded.

---
 rtl/mips_if_pkg.sv | 18 +
 rtl/if_fetch_unit_if.sv | 19 +
 rtl/if_fetch_buf.sv | 40 ++++
 rtl/if_fetch_unit.sv | 103 ++++++++++
 tb/tb_if_fetch_unit.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_if_pkg.sv
// Shared types and constants for the instruction-fetch front end:
// FSM state encoding, nop encoding, default reset PC, word-align helper.
package mips_if_pkg;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus.
// master: fetch unit (Req/Addr out); slave: memory (Ready/Valid/RData out).
interface if_fetch_unit_if;
  logic        IMEM_Req;
  logic [31:0] IMEM_Addr;
  logic        IMEM_Ready;
  logic        IMEM_Valid;
  logic [31:0] IMEM_RData;

  modport master (
    output IMEM_Req, IMEM_Addr,
    input  IMEM_Ready, IMEM_Valid, IMEM_RData
  );

  modport slave (
    input  IMEM_Req, IMEM_Addr,
    output IMEM_Ready, IMEM_Valid, IMEM_RData
  );
endinterface

// File: rtl/if_fetch_buf.sv
// One-entry fetch buffer {instr, pc4, valid} feeding IF/ID.
// Ports: clk/rst, load/consume/flush controls, load data, buffered outputs.
module if_fetch_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        consume,
  input  logic        flush,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc4,
  output logic [31:0] instr,
  output logic [31:0] pc4,
  output logic        valid
);
  import mips_if_pkg::*;

  logic [31:0] instr_q;
  logic [31:0] pc4_q;
  logic        valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (load) begin
      instr_q <= load_instr;
      pc4_q   <= load_pc4;
      valid_q <= 1'b1;
    end else if (consume) begin
      valid_q <= 1'b0;
    end
  end

  assign instr = valid_q ? instr_q : NOP_INSTR;
  assign pc4   = pc4_q;
  assign valid = valid_q;
endmodule

// File: rtl/if_fetch_unit.sv
// IF front end: PC, one-outstanding IMEM fetch FSM, redirect/stall handling.
// Ports: CLK/RESET, hazard+redirect inputs, imem bus (master), IF_* outputs.
// Optional IF_FETCH_CNT_EN adds Fetch_Count / Discard_Count outputs.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = mips_if_pkg::RESET_PC_DEF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        PCWrite,
  input  logic        Branch,
  input  logic [31:0] BTB_Addr,
  input  logic        JUMP,
  input  logic [31:0] JUMP_Addr,
  if_fetch_unit_if.master imem,
  output logic [31:0] IF_Instruction,
  output logic [31:0] IF_PC_4,
`ifdef IF_FETCH_CNT_EN
  output logic [31:0] Fetch_Count,
  output logic [31:0] Discard_Count,
`endif
  output logic        IF_Valid
);
  import mips_if_pkg::*;

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  pc_inflight;
  logic [31:0]  target;
  logic         redirect;
  logic         consume;
  logic         req;
  logic         accept;
  logic         load;
  logic         drop;

  assign redirect = PCWrite & (Branch | JUMP);
  assign target   = word_align(Branch ? BTB_Addr : JUMP_Addr);
  assign consume  = IF_Valid & PCWrite & ~redirect;

  // Only request when the response is guaranteed a free buffer slot.
  assign req    = (state == S_REQ) & (~IF_Valid | consume);
  assign accept = req & imem.IMEM_Ready;
  assign load   = (state == S_WAIT) & imem.IMEM_Valid & ~redirect;
  assign drop   = (state != S_REQ) & imem.IMEM_Valid & ~load;

  assign imem.IMEM_Req  = req;
  assign imem.IMEM_Addr = pc;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      pc_inflight <= RESET_PC;
    end else begin
      unique case (state)
        S_REQ: begin
          if (accept) begin
            pc_inflight <= pc;
            state       <= redirect ? S_DRAIN : S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem.IMEM_Valid) state <= S_REQ;
          else if (redirect)   state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (imem.IMEM_Valid) state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
      if (redirect)    pc <= target;
      else if (accept) pc <= pc + 32'd4;
    end
  end

  if_fetch_buf u_buf (
    .clk        (CLK),
    .rst        (RESET),
    .load       (load),
    .consume    (consume),
    .flush      (redirect),
    .load_instr (imem.IMEM_RData),
    .load_pc4   (pc_inflight + 32'd4),
    .instr      (IF_Instruction),
    .pc4        (IF_PC_4),
    .valid      (IF_Valid)
  );

`ifdef IF_FETCH_CNT_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      Fetch_Count   <= 32'h0;
      Discard_Count <= 32'h0;
    end else begin
      if (load) Fetch_Count   <= Fetch_Count + 32'd1;
      if (drop) Discard_Count <= Discard_Count + 32'd1;
    end
  end
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: memory model plus a scoreboard
// of expected {instr, pc4} pushed on request accept, popped on IF_Valid.
module tb_if_fetch_unit;
  import mips_if_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        PCWrite = 1'b0;
  logic        Branch = 1'b0;
  logic        JUMP = 1'b0;
  logic [31:0] BTB_Addr = 32'h0;
  logic [31:0] JUMP_Addr = 32'h0;
  logic [31:0] IF_Instruction;
  logic [31:0] IF_PC_4;
  logic        IF_Valid;
`ifdef IF_FETCH_CNT_EN
  logic [31:0] Fetch_Count;
  logic [31:0] Discard_Count;
`endif

  if_fetch_unit_if bus();

  if_fetch_unit dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .PCWrite        (PCWrite),
    .Branch         (Branch),
    .BTB_Addr       (BTB_Addr),
    .JUMP           (JUMP),
    .JUMP_Addr      (JUMP_Addr),
    .imem           (bus),
    .IF_Instruction (IF_Instruction),
    .IF_PC_4        (IF_PC_4),
`ifdef IF_FETCH_CNT_EN
    .Fetch_Count    (Fetch_Count),
    .Discard_Count  (Discard_Count),
`endif
    .IF_Valid       (IF_Valid)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  function automatic logic [31:0] mem(logic [31:0] a);
    if (a == 32'h0) return 32'h8FA8_0000;
    if (a == 32'h4) return 32'h00A6_3820;
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mpc = 32'h0;
  logic        prev_v = 1'b0;
  logic        acc_s = 1'b0;
  logic [31:0] acc_a = 32'h0;
  logic        hold_rsp = 1'b0;
  logic        pend = 1'b0;
  logic [31:0] paddr = 32'h0;

  // Monitor / scoreboard, sampled mid-cycle.
  always @(negedge CLK) begin : mon
    exp_t e;
    logic redir;
    if (RESET) begin
      sb.delete();
      mpc    = 32'h0;
      prev_v = 1'b0;
      acc_s  = 1'b0;
    end else begin
      redir = PCWrite & (Branch | JUMP);
      if (IF_Valid && !prev_v) begin
        if (sb.size() == 0) begin
          chk("sb_extra", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          chk("if_instr", IF_Instruction, e.instr);
          chk("if_pc4", IF_PC_4, e.pc4);
        end
      end
      prev_v = IF_Valid;
      acc_s  = bus.IMEM_Req & bus.IMEM_Ready;
      acc_a  = bus.IMEM_Addr;
      if (acc_s) begin
        chk("imem_addr", bus.IMEM_Addr, mpc);
        if (!redir) begin
          sb.push_back({mem(mpc), mpc + 32'd4});
          mpc = mpc + 32'd4;
        end
      end
      if (redir) begin
        mpc = (Branch ? BTB_Addr : JUMP_Addr) & 32'hFFFF_FFFC;
        sb.delete();
      end
    end
  end

  // Memory: answers an accepted request one cycle later unless held.
  always @(posedge CLK) begin
    #1;
    if (bus.IMEM_Valid) pend = 1'b0;
    if (acc_s) begin
      pend  = 1'b1;
      paddr = acc_a;
    end
    bus.IMEM_Valid = pend & ~hold_rsp;
    bus.IMEM_RData = bus.IMEM_Valid ? mem(paddr) : 32'hDEAD_BEEF;
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic wait_valid(string tag);
    int n = 0;
    while (!IF_Valid && n < 40) begin
      tick();
      n++;
    end
    chk(tag, 32'(IF_Valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bus.IMEM_Ready = 1'b0;
    bus.IMEM_Valid = 1'b0;
    bus.IMEM_RData = 32'h0;
    tick();
    tick();
    chk("rst_valid", 32'(IF_Valid), 32'd0);
    chk("rst_instr", IF_Instruction, 32'h0);
    chk("rst_pc4", IF_PC_4, 32'h0);
    chk("rst_req", 32'(bus.IMEM_Req), 32'd1);
    chk("rst_addr", bus.IMEM_Addr, 32'h0);

    RESET = 1'b0;
    bus.IMEM_Ready = 1'b1;
    PCWrite = 1'b1;
    tick();
    tick();
    chk("first_valid", 32'(IF_Valid), 32'd1);
    chk("first_instr", IF_Instruction, 32'h8FA8_0000);
    tick();
    tick();
    chk("second_instr", IF_Instruction, 32'h00A6_3820);
    chk("second_pc4", IF_PC_4, 32'h8);

    PCWrite = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_instr", IF_Instruction, 32'h00A6_3820);
      chk("stall_pc4", IF_PC_4, 32'h8);
      chk("stall_req", 32'(bus.IMEM_Req), 32'd0);
    end

    PCWrite = 1'b1;
    hold_rsp = 1'b1;
    tick();
    BTB_Addr = 32'h40;
    Branch = 1'b1;
    chk("br_pre_valid", 32'(IF_Valid), 32'd0);
    tick();
    Branch = 1'b0;
    hold_rsp = 1'b0;
    chk("drain_req", 32'(bus.IMEM_Req), 32'd0);
    chk("drain_addr", bus.IMEM_Addr, 32'h40);
    wait_valid("br_tmo");
    chk("br_pc4", IF_PC_4, 32'h44);
    chk("br_instr", IF_Instruction, mem(32'h40));
`ifdef IF_FETCH_CNT_EN
    chk("discard_cnt", Discard_Count, 32'd1);
    chk("fetch_cnt", Fetch_Count, 32'd3);
`endif

    BTB_Addr = 32'h20;
    Branch = 1'b1;
    JUMP_Addr = 32'h80;
    JUMP = 1'b1;
    tick();
    Branch = 1'b0;
    JUMP = 1'b0;
    chk("prio_addr", bus.IMEM_Addr, 32'h20);
    wait_valid("prio_tmo");
    chk("prio_pc4", IF_PC_4, 32'h24);

    JUMP_Addr = 32'h83;
    JUMP = 1'b1;
    tick();
    JUMP = 1'b0;
    chk("jalign_addr", bus.IMEM_Addr, 32'h80);
    wait_valid("jalign_tmo");
    chk("jalign_pc4", IF_PC_4, 32'h84);

    JUMP_Addr = 32'hFFFF_FFFC;
    JUMP = 1'b1;
    tick();
    JUMP = 1'b0;
    wait_valid("wrap_tmo");
    chk("wrap_pc4", IF_PC_4, 32'h0);
    chk("wrap_addr", bus.IMEM_Addr, 32'h0);

    JUMP_Addr = 32'h100;
    JUMP = 1'b1;
    tick();
    JUMP = 1'b0;
    wait_valid("pre_rst_tmo");
    hold_rsp = 1'b1;
    tick();
    chk("wait_req", 32'(bus.IMEM_Req), 32'd0);
    RESET = 1'b1;
    #1;
    chk("arst_valid", 32'(IF_Valid), 32'd0);
    chk("arst_instr", IF_Instruction, 32'h0);
    chk("arst_pc4", IF_PC_4, 32'h0);
    chk("arst_addr", bus.IMEM_Addr, 32'h0);
    chk("arst_req", 32'(bus.IMEM_Req), 32'd1);
    bus.IMEM_Ready = 1'b0;
    tick();
    RESET = 1'b0;
    hold_rsp = 1'b0;
    tick();
    tick();
    chk("stale_valid", 32'(IF_Valid), 32'd0);
    chk("stale_addr", bus.IMEM_Addr, 32'h0);

    bus.IMEM_Ready = 1'b1;
    wait_valid("restart_tmo");
    bus.IMEM_Ready = 1'b0;
    chk("restart_instr", IF_Instruction, 32'h8FA8_0000);
    chk("restart_pc4", IF_PC_4, 32'h4);
    tick();
    tick();
    tick();
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
